// File: rtl/fifo_bank.sv
// Bank of independent circular FIFOs with broadcast write and a staggered (systolic) read sequencer.
// Read data is registered (1-cycle latency); writes to a full channel are dropped and flagged in overflow.
module fifo_bank #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4,
  parameter int CHANNELS  = 9,
  parameter int AF_LEVEL  = 14
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic [CHANNELS-1:0]                  wr_en,
  input  logic [DATA_W*CHANNELS-1:0]           wr_data,
  input  logic                                 bcast,
  input  logic [CHANNELS-1:0]                  rd_en,
  input  logic                                 skew_start,
  input  logic [LOG_DEPTH:0]                   skew_len,
  output logic [DATA_W*CHANNELS-1:0]           rd_data,
  output logic [CHANNELS-1:0]                  rd_valid,
  output logic [CHANNELS-1:0]                  empty,
  output logic [CHANNELS-1:0]                  full,
  output logic [CHANNELS-1:0]                  almost_full,
  output logic [(LOG_DEPTH+1)*CHANNELS-1:0]    count,
  output logic [CHANNELS-1:0]                  overflow,
  output logic                                 busy
);
  localparam int CW     = LOG_DEPTH + 1;
  localparam int DCW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW     = (CW > DCW) ? CW : DCW;
  localparam logic [CW-1:0]        FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0]        AF_CNT     = CW'(AF_LEVEL);
  localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);
  localparam logic [TW-1:0]        TMR_ONE    = TW'(1);
  localparam logic [TW-1:0]        DRAIN_LAST = TW'((CHANNELS > 1) ? CHANNELS - 2 : 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [CHANNELS-1:0]   wave_q, wave_d;

  logic [DATA_W-1:0]     mem_q    [CHANNELS][DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr_q [CHANNELS];
  logic [LOG_DEPTH-1:0]  rd_ptr_q [CHANNELS];
  logic [CW-1:0]         cnt_q    [CHANNELS];
  logic [CHANNELS-1:0]   ovf_q, vld_q;
  logic [DATA_W*CHANNELS-1:0] rdat_q;

  logic [CHANNELS-1:0]   eff_rd, rd_ok, wr_ok;
  logic [DATA_W-1:0]     wdat [CHANNELS];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (skew_start && (skew_len != '0)) begin
          state_d = RUN;
          tmr_d   = TW'(skew_len) - TMR_ONE;
        end
      end
      RUN: begin
        if (tmr_q == '0) begin
          if (CHANNELS > 1) begin
            state_d = DRAIN;
            tmr_d   = DRAIN_LAST;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      DRAIN: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TMR_ONE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      tmr_d   = '0;
    end
  end

  assign wave_d = clear ? '0 : ((wave_q << 1) | CHANNELS'(state_q == RUN));
  assign busy   = (state_q != IDLE);

  // The wave's last bit reaches the top channel one cycle after DRAIN ends; keep manual reads masked until it exits.
  assign eff_rd = (busy || (wave_q != '0)) ? wave_q : rd_en;

  always_comb begin
    rd_ok = '0;
    for (int i = 0; i < CHANNELS; i++) rd_ok[i] = eff_rd[i] && (cnt_q[i] != '0);
  end

  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_ok[i] = wr_en[i] && ((cnt_q[i] != FULL_CNT) || rd_ok[i]);
      wdat[i]  = bcast ? wr_data[DATA_W-1:0] : wr_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    empty       = '0;
    full        = '0;
    almost_full = '0;
    count       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      empty[i]            = (cnt_q[i] == '0);
      full[i]             = (cnt_q[i] == FULL_CNT);
      almost_full[i]      = (cnt_q[i] >= AF_CNT);
      count[i*CW +: CW]   = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      wave_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      wave_q  <= wave_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q  <= '0;
      vld_q  <= '0;
      rdat_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q <= '0;
      vld_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        vld_q[i] <= rd_ok[i];
        if (rd_ok[i]) begin
          rdat_q[i*DATA_W +: DATA_W] <= mem_q[i][rd_ptr_q[i]];
          rd_ptr_q[i]                <= rd_ptr_q[i] + PTR_ONE;
        end
        if (wr_ok[i])              wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
        if (wr_en[i] && !wr_ok[i]) ovf_q[i]    <= 1'b1;
        if (wr_ok[i] && !rd_ok[i])      cnt_q[i] <= cnt_q[i] + CNT_ONE;
        else if (!wr_ok[i] && rd_ok[i]) cnt_q[i] <= cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Storage is not reset; pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_ok[i] && !clear) mem_q[i][wr_ptr_q[i]] <= wdat[i];
    end
  end

  assign rd_data  = rdat_q;
  assign rd_valid = vld_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fifo_bank.sv
// Directed and random stimulus for fifo_bank, checked every cycle against a queue-based reference model.
module tb_fifo_bank;
  localparam int DW = 16, DEPTH = 16, LD = 4, CH = 9, AF = 14, CWD = LD + 1;

  logic clk = 1'b0;
  logic rst_n, clear, bcast, skew_start, busy;
  logic [CH-1:0] wr_en, rd_en, rd_valid, empty, full, almost_full, overflow;
  logic [DW*CH-1:0] wr_data, rd_data;
  logic [LD:0] skew_len;
  logic [CWD*CH-1:0] count;

  always #5 clk = ~clk;

  fifo_bank #(.DATA_W(DW), .DEPTH(DEPTH), .LOG_DEPTH(LD), .CHANNELS(CH), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .bcast(bcast),
    .rd_en(rd_en), .skew_start(skew_start), .skew_len(skew_len), .rd_data(rd_data),
    .rd_valid(rd_valid), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .busy(busy)
  );

  int n_assert = 0, n_fail = 0;

  // Reference model: one queue per channel plus burst bookkeeping by cycle index.
  logic [DW-1:0]    mq [CH][$];
  logic [CH-1:0]    m_ovf, m_vld;
  logic [DW*CH-1:0] m_dat;
  bit               m_act;
  int               m_k, m_len;

  function automatic bit m_busy();
    return m_act && (m_k <= m_len + CH - 2);
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < CH; i++) mq[i].delete();
    m_ovf = '0; m_vld = '0; m_dat = '0; m_act = 0; m_k = 0; m_len = 0;
  endtask

  task automatic m_step();
    bit rdok, wrok;
    logic [DW-1:0] v;
    if (clear) begin
      for (int i = 0; i < CH; i++) mq[i].delete();
      m_ovf = '0; m_vld = '0; m_act = 0;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      if (m_act) rdok = (m_k >= 1 + i) && (m_k <= m_len + i);
      else       rdok = rd_en[i];
      rdok = rdok && (mq[i].size() > 0);
      wrok = wr_en[i] && ((mq[i].size() < DEPTH) || rdok);
      m_vld[i] = rdok;
      if (rdok) begin
        v = mq[i].pop_front();
        m_dat[i*DW +: DW] = v;
      end
      if (wrok) mq[i].push_back(bcast ? wr_data[DW-1:0] : wr_data[i*DW +: DW]);
      else if (wr_en[i]) m_ovf[i] = 1'b1;
    end
    if (m_act) begin
      m_k++;
      if (m_k > m_len + CH - 1) m_act = 0;
    end else if (skew_start && (skew_len != '0)) begin
      m_act = 1; m_k = 0; m_len = int'(skew_len);
    end
  endtask

  task automatic check_all();
    logic [CWD*CH-1:0] ecnt;
    logic [CH-1:0] ee, ef, eaf;
    for (int i = 0; i < CH; i++) begin
      ecnt[i*CWD +: CWD] = CWD'(mq[i].size());
      ee[i]  = (mq[i].size() == 0);
      ef[i]  = (mq[i].size() == DEPTH);
      eaf[i] = (mq[i].size() >= AF);
    end
    chk("rd_valid", 256'(rd_valid), 256'(m_vld));
    chk("rd_data", 256'(rd_data), 256'(m_dat));
    chk("count", 256'(count), 256'(ecnt));
    chk("empty", 256'(empty), 256'(ee));
    chk("full", 256'(full), 256'(ef));
    chk("almost_full", 256'(almost_full), 256'(eaf));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("busy", 256'(busy), 256'(m_busy()));
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    clear = 0; bcast = 0; skew_start = 0; skew_len = '0;
    wr_en = '0; rd_en = '0; wr_data = '0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH; i++) wr_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic wr1(input int ch, input logic [DW-1:0] d);
    idle();
    wr_en[ch] = 1'b1;
    wr_data[ch*DW +: DW] = d;
    step();
  endtask

  task automatic do_clear();
    idle(); clear = 1; step(); idle();
  endtask

  task automatic fill_all(input int n);
    for (int w = 0; w < n; w++) begin
      idle(); wr_en = '1; rand_data(); step();
    end
  endtask

  int first_v [CH];
  int nv [CH];
  int busy_n;

  initial begin
    rst_n = 0;
    idle();
    m_reset();
    #12;
    check_all();
    chk("reset_empty", 256'(empty), 256'({CH{1'b1}}));
    chk("reset_busy", 256'(busy), 256'(0));
    @(negedge clk) rst_n = 1;
    step();

    // 16-deep fill, overflow on the 17th, in-order drain
    for (int d = 0; d < 16; d++) wr1(3, DW'(d));
    wr1(3, 16'h0010);
    chk("c39_count", 256'(count[3*CWD +: CWD]), 256'(16));
    chk("c39_full", 256'(full[3]), 256'(1));
    chk("c39_ovf", 256'(overflow[3]), 256'(1));
    for (int j = 0; j < 16; j++) begin
      idle(); rd_en[3] = 1'b1; step();
      chk("c39_rd", 256'(rd_data[3*DW +: DW]), 256'(j));
      chk("c39_vld", 256'(rd_valid[3]), 256'(1));
    end

    // broadcast
    do_clear();
    idle(); bcast = 1; wr_en = '1; rand_data(); wr_data[DW-1:0] = 16'hABCD; step();
    chk("c40_count", 256'(count), 256'({CH{5'd1}}));
    idle(); rd_en = '1; step();
    chk("c40_data", 256'(rd_data), 256'({CH{16'hABCD}}));
    chk("c40_vld", 256'(rd_valid), 256'({CH{1'b1}}));

    // staggered burst; manual reads and a second start are ignored while busy
    do_clear();
    fill_all(4);
    for (int i = 0; i < CH; i++) begin first_v[i] = -1; nv[i] = 0; end
    busy_n = 0;
    for (int s = 0; s <= 14; s++) begin
      idle();
      if (s == 0) begin skew_start = 1; skew_len = 5'd4; end
      if (s == 3) begin skew_start = 1; skew_len = 5'd2; end
      if (s >= 1 && s <= 9) rd_en = '1;
      step();
      if (busy) busy_n++;
      for (int i = 0; i < CH; i++) if (rd_valid[i]) begin
        nv[i]++;
        if (first_v[i] < 0) first_v[i] = s;
      end
    end
    for (int i = 0; i < CH; i++) begin
      chk("c41_first", 256'(first_v[i]), 256'(2 + i));
      chk("c41_len", 256'(nv[i]), 256'(4));
    end
    chk("c41_busy", 256'(busy_n), 256'(12));

    // simultaneous read+write on a full and on an empty channel
    do_clear();
    for (int d = 0; d < 16; d++) wr1(0, DW'($urandom));
    idle(); wr_en[1:0] = 2'b11; rd_en[1:0] = 2'b11; rand_data(); step();
    chk("c42_cnt0", 256'(count[0 +: CWD]), 256'(16));
    chk("c42_ovf0", 256'(overflow[0]), 256'(0));
    chk("c42_vld0", 256'(rd_valid[0]), 256'(1));
    chk("c42_cnt1", 256'(count[CWD +: CWD]), 256'(1));
    chk("c42_vld1", 256'(rd_valid[1]), 256'(0));

    // clear mid-burst
    do_clear();
    fill_all(4);
    idle(); skew_start = 1; skew_len = 5'd4; step();
    idle(); for (int s = 0; s < 3; s++) step();
    clear = 1; step(); idle();
    chk("c43_busy", 256'(busy), 256'(0));
    chk("c43_count", 256'(count), 256'(0));
    chk("c43_vld", 256'(rd_valid), 256'(0));
    rd_en = '1; step();
    chk("c43_rd", 256'(rd_valid), 256'(0));

    // almost_full threshold
    do_clear();
    for (int d = 0; d < 13; d++) wr1(5, DW'($urandom));
    chk("c44_af13", 256'(almost_full[5]), 256'(0));
    wr1(5, 16'h1234);
    chk("c44_af14", 256'(almost_full[5]), 256'(1));
    idle(); rd_en[5] = 1'b1; step();
    chk("c44_af_rd", 256'(almost_full[5]), 256'(0));

    // random traffic
    do_clear();
    for (int n = 0; n < 700; n++) begin
      idle();
      wr_en = CH'($urandom) | CH'($urandom);
      rd_en = CH'($urandom) & CH'($urandom);
      rand_data();
      bcast = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 11) == 0 && !(m_act && m_k == m_len + CH - 1)) begin
        skew_start = 1;
        skew_len = 5'($urandom_range(0, 16));
      end
      step();
    end

    // asynchronous reset mid-burst
    do_clear();
    fill_all(4);
    idle(); skew_start = 1; skew_len = 5'd4; step();
    idle(); for (int s = 0; s < 3; s++) step();
    #2 rst_n = 0;
    m_reset();
    #1;
    check_all();
    chk("rst_busy", 256'(busy), 256'(0));
    @(negedge clk) rst_n = 1;
    for (int s = 0; s < 6; s++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
